// File: rtl/store_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : store_datapath_if
// Purpose  : Config, rate-block and output-word handshakes of the SHAKE store stage.
// Revision : 1.0
// ============================================================================
interface store_datapath_if #(
   parameter int W    = 64,
   parameter int RATE = 1344
);
   logic [1:0]      operation_mode;
   logic [31:0]     output_size;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [RATE-1:0] rate_output;
   logic            rate_valid;
   logic            rate_ready;
   logic            squeeze_request;
   logic [W-1:0]    data_out;
   logic            data_out_valid;
   logic            data_out_ready;
   logic            done;

   // Upstream/sink side: drives config, blocks and output backpressure
   modport master (
      output operation_mode, output_size, cfg_valid,
      input  cfg_ready,
      output rate_output, rate_valid,
      input  rate_ready, squeeze_request,
      input  data_out, data_out_valid,
      output data_out_ready,
      input  done
   );

   modport slave (
      input  operation_mode, output_size, cfg_valid,
      output cfg_ready,
      input  rate_output, rate_valid,
      output rate_ready, squeeze_request,
      output data_out, data_out_valid,
      input  data_out_ready,
      output done
   );
endinterface
`default_nettype wire

// File: rtl/store_datapath.sv
`default_nettype none
// ============================================================================
// Module   : store_datapath
// Purpose  : Serializes squeezed SHAKE rate blocks into byte-swapped output words,
//            requesting further squeezes until the requested length is produced.
//            Optional macro STORE_OUTPUT_MASK_EN zeroes unused bytes of the last word.
// Revision : 1.0
// ============================================================================
module store_datapath #(
   parameter int         W                 = 64,
   parameter int         RATE              = 1344,
   parameter logic [1:0] SHAKE128_MODE_VEC = 2'b01,
   parameter logic [1:0] SHAKE256_MODE_VEC = 2'b10
) (
   input  logic            clk,
   input  logic            rst,
   store_datapath_if.slave bus
);

   localparam int                WORDS128 = 1344 / W;
   localparam int                WORDS256 = 1088 / W;
   localparam int                CNT_W    = $clog2(WORDS128);
   localparam int                NBYTES   = W / 8;
   localparam logic [CNT_W-1:0]  LAST128  = CNT_W'(WORDS128 - 1);
   localparam logic [CNT_W-1:0]  LAST256  = CNT_W'(WORDS256 - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [31:0]       W32      = 32'(W);
   localparam logic [RATE-1:0]   KEEP256  = {{(RATE-1088){1'b0}}, {1088{1'b1}}};

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_BLOCK = 2'd1,
      DRAIN      = 2'd2,
      FINISH     = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             mode256_q, mode256_d;
   logic [31:0]      remaining_q, remaining_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [RATE-1:0]  block_q, block_d;

   logic             out_hs;
   logic             last_in_block;
   logic             last_word;
   logic             squeeze_d;
   logic [W-1:0]     cur_word;
   logic [W-1:0]     swapped;
   logic [W-1:0]     masked;

   assign out_hs        = (state_q == DRAIN) && bus.data_out_ready;
   assign last_in_block = (word_cnt_q == (mode256_q ? LAST256 : LAST128));
   assign last_word     = (remaining_q <= W32);
   assign cur_word      = block_q[W-1:0];

   // Lane byte 0 is the first stream byte, so it goes to the top of the word
   for (genvar b = 0; b < NBYTES; b++) begin : g_swap
      assign swapped[W-1-8*b -: 8] = cur_word[8*b +: 8];
   end

`ifdef STORE_OUTPUT_MASK_EN
   logic [4:0] raw_bytes;
   logic [3:0] valid_bytes;

   assign raw_bytes   = {1'b0, remaining_q[6:3]} + {4'd0, |remaining_q[2:0]};
   assign valid_bytes = (raw_bytes > 5'd8) ? 4'd8 : raw_bytes[3:0];

   for (genvar b = 0; b < NBYTES; b++) begin : g_mask
      assign masked[W-1-8*b -: 8] = (!last_word || (4'(b) < valid_bytes))
                                    ? swapped[W-1-8*b -: 8] : 8'h00;
   end
`else
   assign masked = swapped;
`endif

   assign bus.cfg_ready       = (state_q == IDLE);
   assign bus.rate_ready      = (state_q == WAIT_BLOCK);
   assign bus.data_out_valid  = (state_q == DRAIN);
   assign bus.data_out        = (state_q == DRAIN) ? masked : '0;
   assign bus.done            = (state_q == FINISH);
   assign bus.squeeze_request = squeeze_d;

   always_comb begin
      state_d     = state_q;
      mode256_d   = mode256_q;
      remaining_d = remaining_q;
      word_cnt_d  = word_cnt_q;
      block_d     = block_q;
      squeeze_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.cfg_valid) begin
               mode256_d   = (bus.operation_mode == SHAKE256_MODE_VEC);
               remaining_d = bus.output_size;
               state_d     = (bus.output_size == 32'd0) ? FINISH : WAIT_BLOCK;
            end
         end
         WAIT_BLOCK: begin
            if (bus.rate_valid) begin
               block_d    = mode256_q ? (bus.rate_output & KEEP256) : bus.rate_output;
               word_cnt_d = '0;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            if (out_hs) begin
               block_d     = block_q >> W;
               word_cnt_d  = word_cnt_q + CNT_ONE;
               remaining_d = last_word ? 32'd0 : (remaining_q - W32);
               if (last_word) begin
                  state_d = FINISH;
               end else if (last_in_block) begin
                  state_d   = WAIT_BLOCK;
                  squeeze_d = 1'b1;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         mode256_q   <= 1'b0;
         remaining_q <= 32'd0;
         word_cnt_q  <= '0;
         block_q     <= '0;
      end else begin
         state_q     <= state_d;
         mode256_q   <= mode256_d;
         remaining_q <= remaining_d;
         word_cnt_q  <= word_cnt_d;
         block_q     <= block_d;
      end
   end

   // SHAKE128_MODE_VEC documents the encoding; every non-SHAKE256 value selects 21 words
   logic unused_mode128;
   assign unused_mode128 = ^SHAKE128_MODE_VEC;

endmodule
`default_nettype wire

// File: tb/tb_store_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_datapath
// Purpose  : Scoreboard bench for store_datapath with directed block/size vectors.
// Revision : 1.0
// ============================================================================
module tb_store_datapath;

   localparam logic [1:0] M128 = 2'b01;
   localparam logic [1:0] M256 = 2'b10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   store_datapath_if #(.W(64), .RATE(1344)) bus ();

   store_datapath #(
      .W(64), .RATE(1344), .SHAKE128_MODE_VEC(M128), .SHAKE256_MODE_VEC(M256)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [63:0] data;
      logic        sq;
      logic        last;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          e;
   int            vectors = 0;
   int            errors  = 0;
   int            cyc     = 0;
   logic          mon_en  = 1'b0;
   logic          bp_en   = 1'b0;
   logic          bubble_chk = 1'b0;
   logic          no_rate = 1'b0;
   logic          done_pending = 1'b0;
   int            done_due = 0;
   logic          hold_v = 1'b0;
   logic [63:0]   hold_d = '0;
   logic          sq_pend = 1'b0;
   int            sq_cyc = 0;
   logic [1343:0] blocks [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [63:0] bswap(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 8; i++) y[8*i +: 8] = x[56-8*i +: 8];
      return y;
   endfunction

   function automatic logic [63:0] lane_pat(input int b, input int k);
      return {8'(b + 1), 8'(k), 48'h0123_4567_89AB};
   endfunction

   task automatic fill_blocks();
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 21; k++)
            blocks[b][64*k +: 64] = lane_pat(b, k);
   endtask

   // Reference: walk the blocks lane by lane, 64 bits of output per word
   task automatic push_model(input logic mode256, input logic [31:0] size);
      longint rem;
      int     b, k, nw;
      exp_t   x;
      nw  = mode256 ? 17 : 21;
      rem = longint'(size);
      b   = 0;
      k   = 0;
      for (int n = 0; n < 200; n++) begin
         x.data = bswap(blocks[b][64*k +: 64]);
         x.last = (rem <= 64);
         x.sq   = (k == nw - 1) && !x.last;
         exp_q.push_back(x);
         if (x.last) break;
         rem = rem - 64;
         k++;
         if (k == nw) begin
            k = 0;
            b++;
         end
      end
   endtask

   task automatic push_word(input logic [63:0] d, input logic last);
      exp_t x;
      x.data = d;
      x.sq   = 1'b0;
      x.last = last;
      exp_q.push_back(x);
   endtask

   task automatic run_cfg(input logic [1:0] mode, input logic [31:0] size, input int nblk);
      int t;
      @(posedge clk); #1;
      bus.operation_mode = mode;
      bus.output_size    = size;
      bus.cfg_valid      = 1'b1;
      t = 0;
      while (!bus.cfg_ready && t < 100) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      if (size == 32'd0) begin
         done_pending = 1'b1;
         done_due     = cyc;
      end
      for (int b = 0; b < nblk; b++) begin
         bus.rate_output = blocks[b];
         bus.rate_valid  = 1'b1;
         t = 0;
         while (!bus.rate_ready && t < 1000) begin @(posedge clk); #1; t++; end
         if (t >= 1000) begin
            vectors++; errors++;
            $display("FAIL rate_wait: rate_ready got 0 expected 1 within 1000 cycles");
         end
         @(posedge clk); #1;
      end
      bus.rate_valid = 1'b0;
      t = 0;
      while ((exp_q.size() != 0 || done_pending) && t < 3000) begin @(posedge clk); #1; t++; end
      if (t >= 3000) begin
         vectors++; errors++;
         $display("FAIL drain_wait: %0d words outstanding expected 0", exp_q.size());
         exp_q.delete();
         done_pending = 1'b0;
      end
      repeat (2) @(posedge clk);
   endtask

   // Monitor: pops the scoreboard on each accepted word
   always @(negedge clk) begin
      if (mon_en) begin
         if (no_rate) check("rate_ready_zero", 64'(bus.rate_ready), 64'd0);
         if (bus.data_out_valid) begin
            if (hold_v) check("hold_stable", bus.data_out, hold_d);
            if (bus.data_out_ready) begin
               hold_v = 1'b0;
               if (exp_q.size() == 0) begin
                  vectors++; errors++;
                  $display("FAIL extra_word: got %h expected no word", bus.data_out);
               end else begin
                  e = exp_q.pop_front();
                  check("data_out", bus.data_out, e.data);
                  check("squeeze_request", 64'(bus.squeeze_request), 64'(e.sq));
                  if (bubble_chk && sq_pend) begin
                     check("bubble_gap", 64'(cyc - sq_cyc), 64'd2);
                     sq_pend = 1'b0;
                  end
                  if (e.sq) begin
                     sq_pend = 1'b1;
                     sq_cyc  = cyc;
                  end
                  if (e.last) begin
                     done_pending = 1'b1;
                     done_due     = cyc + 1;
                  end
               end
            end else begin
               hold_v = 1'b1;
               hold_d = bus.data_out;
               check("stray_squeeze", 64'(bus.squeeze_request), 64'd0);
            end
         end else begin
            hold_v = 1'b0;
            check("stray_squeeze", 64'(bus.squeeze_request), 64'd0);
         end
         if (done_pending && cyc == done_due) begin
            check("done", 64'(bus.done), 64'd1);
            done_pending = 1'b0;
         end else begin
            check("stray_done", 64'(bus.done), 64'd0);
         end
      end
   end

   initial begin
      bus.data_out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.data_out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bus.operation_mode = M128;
      bus.output_size    = '0;
      bus.cfg_valid      = 1'b0;
      bus.rate_output    = '0;
      bus.rate_valid     = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data_out", bus.data_out, 64'd0);
      check("rst_valid", 64'(bus.data_out_valid), 64'd0);
      check("rst_rate_ready", 64'(bus.rate_ready), 64'd0);
      check("rst_squeeze", 64'(bus.squeeze_request), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
      @(posedge clk); #1;
      rst    = 1'b1;
      mon_en = 1'b1;

      // SHAKE128, 256 bits, lane k = k
      blocks[0] = '0;
      for (int k = 0; k < 21; k++) blocks[0][64*k +: 64] = 64'(k);
      push_word(64'h0000_0000_0000_0000, 1'b0);
      push_word(64'h0100_0000_0000_0000, 1'b0);
      push_word(64'h0200_0000_0000_0000, 1'b0);
      push_word(64'h0300_0000_0000_0000, 1'b1);
      run_cfg(M128, 32'd256, 1);

      // SHAKE128, 1408 bits: full block, squeeze, one more word
      fill_blocks();
      sq_pend    = 1'b0;
      bubble_chk = 1'b1;
      push_model(1'b0, 32'd1408);
      run_cfg(M128, 32'd1408, 2);
      bubble_chk = 1'b0;

      // SHAKE256, 1088 bits, top 256 bits poisoned
      fill_blocks();
      blocks[0][1343:1088] = '1;
      push_model(1'b1, 32'd1088);
      run_cfg(M256, 32'd1088, 1);

      // 200 bits of all-ones: last word carries one valid byte
      blocks[0] = '1;
      push_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      push_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      push_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`ifdef STORE_OUTPUT_MASK_EN
      push_word(64'hFF00_0000_0000_0000, 1'b1);
`else
      push_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
`endif
      run_cfg(M128, 32'd200, 1);

      // 4096 bits, unlisted mode value, without then with backpressure
      fill_blocks();
      push_model(1'b0, 32'd4096);
      run_cfg(2'b00, 32'd4096, 4);
      bp_en = 1'b1;
      push_model(1'b0, 32'd4096);
      run_cfg(2'b00, 32'd4096, 4);
      bp_en = 1'b0;
      repeat (2) @(posedge clk);

      // Zero-size request
      no_rate = 1'b1;
      run_cfg(M128, 32'd0, 0);
      no_rate = 1'b0;

      // Reset in the middle of a drain
      fill_blocks();
      push_model(1'b0, 32'd1408);
      @(posedge clk); #1;
      bus.operation_mode = M128;
      bus.output_size    = 32'd1408;
      bus.cfg_valid      = 1'b1;
      @(posedge clk); #1;
      bus.cfg_valid   = 1'b0;
      bus.rate_output = blocks[0];
      bus.rate_valid  = 1'b1;
      t = 0;
      while (!bus.data_out_valid && t < 100) begin @(posedge clk); #1; t++; end
      bus.rate_valid = 1'b0;
      check("drain_started", 64'(bus.data_out_valid), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rstmid_valid", 64'(bus.data_out_valid), 64'd0);
      check("rstmid_cfg_ready", 64'(bus.cfg_ready), 64'd1);
      check("rstmid_done", 64'(bus.done), 64'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("post_rst_idle", 64'(bus.cfg_ready), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
